// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus sequencer: FSM states, decoded regions, open-bus default
// and the access counter width.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold
    } state_e;

    typedef enum logic [1:0] {
        RegRom,
        RegRam,
        RegNone
    } region_e;

    localparam logic [7:0]  OpenBus  = 8'h00;
    localparam int unsigned CntWidth = 4;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side handshake plus device address and strobes of the memory bus sequencer.
// The bidirectional device data bus is kept as a plain port on the sequencer.
interface mem_bus_ctrl_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [15:0] mem_addr;
    logic        rom_oe_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        bus_fault;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, mem_addr, rom_oe_n, ram_oe_n, ram_we_n, bus_fault
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, mem_addr, rom_oe_n, ram_oe_n, ram_we_n, bus_fault
    );

endinterface

// File: rtl/mem_addr_decode.sv
// Combinational address decoder: CPU address to region and region-relative offset.
// ROM wins over RAM when both windows match; unmapped addresses pass through unchanged.
module mem_addr_decode
    import mem_bus_pkg::*;
#(
    parameter logic [15:0] ROM_BASE = 16'hFFE0,
    parameter logic [15:0] ROM_MASK = 16'hFFE0,
    parameter logic [15:0] RAM_BASE = 16'h0000,
    parameter logic [15:0] RAM_MASK = 16'hF800
) (
    input  logic [15:0] addr_i,
    output region_e     region_o,
    output logic [15:0] offset_o
);

    always_comb begin
        region_o = RegNone;
        offset_o = addr_i;
        if ((addr_i & ROM_MASK) == ROM_BASE) begin
            region_o = RegRom;
            offset_o = addr_i & ~ROM_MASK;
        end else if ((addr_i & RAM_MASK) == RAM_BASE) begin
            region_o = RegRam;
            offset_o = addr_i & ~RAM_MASK;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus sequencer: one CPU access at a time into ROM/RAM with setup/strobe/hold timing.
// Define MEM_BUS_WRITE_PROTECT_EN to flag ROM/unmapped writes on a sticky bus_fault.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter logic [15:0] ROM_BASE   = 16'hFFE0,
    parameter logic [15:0] ROM_MASK   = 16'hFFE0,
    parameter logic [15:0] RAM_BASE   = 16'h0000,
    parameter logic [15:0] RAM_MASK   = 16'hF800,
    parameter int unsigned ACCESS_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_bus_ctrl_if.slave bus,
    inout  wire  [7:0]    mem_data
);

    localparam logic [CntWidth-1:0] AccessCnt = CntWidth'(ACCESS_CYC);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    region_e             region_q, region_d, dec_region;
    logic [15:0]         addr_q, addr_d, dec_offset;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                last_cyc;
    logic                drive_en;

    mem_addr_decode #(
        .ROM_BASE (ROM_BASE),
        .ROM_MASK (ROM_MASK),
        .RAM_BASE (RAM_BASE),
        .RAM_MASK (RAM_MASK)
    ) u_decode (
        .addr_i   (bus.cpu_addr),
        .region_o (dec_region),
        .offset_o (dec_offset)
    );

    assign last_cyc = (cnt_q == CntWidth'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req) state_d = StSetup;
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = AccessCnt;
            end
            StAccess: begin
                cnt_d = cnt_q - CntWidth'(1);
                if (last_cyc) state_d = StHold;
            end
            StHold: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are pure functions of the registered state, so reset releases them on one edge.
    always_comb begin
        bus.rom_oe_n = 1'b1;
        bus.ram_oe_n = 1'b1;
        bus.ram_we_n = 1'b1;
        drive_en     = 1'b0;
        bus.cpu_ack  = (state_q == StHold);
        if (state_q == StAccess) begin
            unique case (region_q)
                RegRom: bus.rom_oe_n = we_q;
                RegRam: begin
                    bus.ram_oe_n = we_q;
                    bus.ram_we_n = !we_q;
                    drive_en     = we_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        region_d = region_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        if (state_q == StIdle && bus.cpu_req) begin
            region_d = dec_region;
            addr_d   = dec_offset;
            we_d     = bus.cpu_we;
            wdata_d  = bus.cpu_wdata;
        end
        // Unmapped reads leave rdata untouched to model an open bus.
        if (state_q == StAccess && last_cyc && !we_q && region_q != RegNone) begin
            rdata_d = mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            region_q <= RegNone;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= OpenBus;
        end else begin
            region_q <= region_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign mem_data      = drive_en ? wdata_q : 8'hzz;
    assign bus.mem_addr  = addr_q;
    assign bus.cpu_rdata = rdata_q;

`ifdef MEM_BUS_WRITE_PROTECT_EN
    logic fault_q, fault_d;

    // Set on the edge entering HOLD so the flag is visible alongside cpu_ack.
    always_comb begin
        fault_d = fault_q;
        if (state_q == StAccess && last_cyc && we_q && region_q != RegRam) fault_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end

    assign bus.bus_fault = fault_q;
`else
    assign bus.bus_fault = 1'b0;
`endif

endmodule
